// File: rtl/ahb_spsram_bridge_v2.sv
// AHB-Lite slave bridging single and SEQ beats onto a single-port SRAM.
// Checks size/alignment/range at accept and bounds the SRAM wait with a timeout.
module ahb_spsram_bridge_v2 #(
  parameter int ADDR_W    = 14,
  parameter int MEM_WORDS = 16384,
  parameter int TIMEOUT   = 255
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic              sram_re,
  output logic [3:0]        sram_maskwe,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout,
  input  logic              sram_write_done,
  input  logic              sram_read_valid
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [3:0]        r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_rdata;

  logic       w_open;
  logic       w_accept;
  logic       w_size_err;
  logic       w_range_err;
  logic       w_err;
  logic       w_done;
  logic       w_tmo;
  logic [3:0] w_mask;
  logic       w_unused;

  assign w_unused = ^{HBURST, HTRANS[0]};

  assign w_open = (r_state == S_IDLE) ||
                  (r_state == S_DONE) ||
                  (r_state == S_ERR2);

  assign w_accept = w_open & HSEL & HREADY & HTRANS[1];

  assign w_size_err = (HSIZE > 3'd2) ||
                      (HSIZE == 3'd1 && HADDR[0]) ||
                      (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

  // Full word index, so addresses beyond the ADDR_W window are caught too
  assign w_range_err = {2'b00, HADDR[31:2]} >= 32'(MEM_WORDS);

  assign w_err = w_size_err | w_range_err;

  always_comb begin
    w_mask = 4'b1111;
    case (HSIZE)
      3'd0:    w_mask = 4'b0001 << HADDR[1:0];
      3'd1:    w_mask = 4'b0011 << {HADDR[1], 1'b0};
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_done = r_write ? sram_write_done : sram_read_valid;
  assign w_tmo  = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept)
          w_next = w_err ? S_ERR1 : S_ISSUE;
        else
          w_next = S_IDLE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_done)
          w_next = S_DONE;
        else if (w_tmo)
          w_next = S_ERR1;
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_mask  <= 4'b0000;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_err) begin
        r_write <= HWRITE;
        r_mask  <= w_mask;
        r_addr  <= HADDR[ADDR_W+1:2];
      end
      if (r_state == S_WAIT && w_next == S_WAIT)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (r_state == S_WAIT && !r_write && sram_read_valid)
        r_rdata <= sram_dout;
    end
  end

  assign HREADYOUT   = w_open;
  assign HRESP       = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA      = r_rdata;
  assign sram_addr   = r_addr;
  assign sram_we     = (r_state == S_ISSUE) && r_write;
  assign sram_re     = (r_state == S_ISSUE) && !r_write;
  assign sram_maskwe = sram_we ? r_mask : 4'b0000;
  assign sram_din    = HWDATA;

endmodule

// File: tb/tb_ahb_spsram_bridge_v2.sv
// Bench for ahb_spsram_bridge_v2: vector table, SRAM model and scoreboard.
// Runs with TIMEOUT = 8 so the timeout path is short.
module tb_ahb_spsram_bridge_v2;

  logic        HCLK = 0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [13:0] sram_addr;
  logic        sram_we;
  logic        sram_re;
  logic [3:0]  sram_maskwe;
  logic [31:0] sram_din;
  logic [31:0] sram_dout;
  logic        sram_write_done;
  logic        sram_read_valid;
  logic        tb_hrdy;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT & tb_hrdy;

  ahb_spsram_bridge_v2 #(
    .ADDR_W(14), .MEM_WORDS(16384), .TIMEOUT(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_re(sram_re),
    .sram_maskwe(sram_maskwe), .sram_din(sram_din),
    .sram_dout(sram_dout), .sram_write_done(sram_write_done),
    .sram_read_valid(sram_read_valid)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  trans;
    logic        hrdy;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        e_strobe;
    logic [3:0]  e_mask;
    logic [13:0] e_saddr;
    logic        e_resp;
    int          e_low;
    logic        e_rdchk;
    logic [31:0] e_rdata;
  } vec_t;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  vec_t        vecs[16];
  vec_t        sb[$];
  logic [13:0] q_baddr[$];
  logic [31:0] q_brd[$];
  logic [31:0] mem[16384];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic mem_write();
    for (int b = 0; b < 4; b++)
      if (sram_maskwe[b])
        mem[sram_addr][b*8 +: 8] = sram_din[b*8 +: 8];
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          low;
    int          s;
    int          guard;
    bit          done;
    logic        seen;
    logic        rl;
    logic [3:0]  m;
    logic [13:0] sa;
    vec_t        e;
    low = 0; s = -1; guard = 0; done = 0;
    seen = 0; rl = 0; m = 0; sa = 0;
    sb.push_back(v);
    HSEL = 1; HTRANS = v.trans; HADDR = v.addr; HSIZE = v.size;
    HWRITE = v.wr; tb_hrdy = v.hrdy; HBURST = 3'b000;
    step();
    HSEL = 0; HTRANS = 2'b00; tb_hrdy = 1; HWDATA = v.wdata;
    while (!done && guard < 40) begin
      sram_write_done = 0;
      sram_read_valid = 0;
      if (sram_we || sram_re) begin
        seen = 1; m = sram_maskwe; sa = sram_addr; s = 0;
        if (sram_we) mem_write();
      end else if (s >= 0) begin
        s++;
      end
      if (s > 0 && s == v.lat) begin
        if (v.wr) sram_write_done = 1;
        else begin
          sram_read_valid = 1;
          sram_dout = mem[sa];
        end
      end
      if (HREADYOUT) done = 1;
      else begin
        low++; rl = HRESP;
        step();
        guard++;
      end
    end
    sram_write_done = 0;
    sram_read_valid = 0;
    e = sb.pop_front();
    if (!done) begin
      n_total++;
      $display("FAIL v%0d timeout: HREADYOUT stuck low", idx);
    end
    chk($sformatf("v%0d resp", idx), 32'(HRESP), 32'(e.e_resp));
    chk($sformatf("v%0d low_cycles", idx), low, e.e_low);
    chk($sformatf("v%0d strobe", idx), 32'(seen), 32'(e.e_strobe));
    if (e.e_strobe) begin
      chk($sformatf("v%0d mask", idx), 32'(m), 32'(e.e_mask));
      chk($sformatf("v%0d saddr", idx), 32'(sa), 32'(e.e_saddr));
    end
    if (low > 0)
      chk($sformatf("v%0d resp_low", idx), 32'(rl), 32'(e.e_resp));
    if (e.e_rdchk)
      chk($sformatf("v%0d rdata", idx), HRDATA, e.e_rdata);
  endtask

  initial begin
    int cyc;
    int beat;
    int nre;
    int guard;
    bit pend;
    bit fin;
    logic [13:0] pa;

    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[16383] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) mem[14'h40 + i] = 32'hB0000040 + i;

    vecs[0]  = '{1, NS, 1, 3'd2, 32'h10, 32'hDEADBEEF, 2, 1, 4'hF, 14'd4, 0, 3, 0, 0};
    vecs[1]  = '{0, NS, 1, 3'd2, 32'h10, 32'h0, 2, 1, 4'h0, 14'd4, 0, 3, 1, 32'hDEADBEEF};
    vecs[2]  = '{1, NS, 1, 3'd0, 32'h3, 32'h11000000, 1, 1, 4'h8, 14'd0, 0, 2, 0, 0};
    vecs[3]  = '{1, NS, 1, 3'd1, 32'h2, 32'h22223333, 1, 1, 4'hC, 14'd0, 0, 2, 0, 0};
    vecs[4]  = '{0, NS, 1, 3'd2, 32'h0, 32'h0, 1, 1, 4'h0, 14'd0, 0, 2, 1, 32'h22220000};
    vecs[5]  = '{1, NS, 1, 3'd2, 32'h10000, 32'h12345678, 1, 0, 4'h0, 14'd0, 1, 1, 0, 0};
    vecs[6]  = '{0, NS, 1, 3'd1, 32'h1, 32'h0, 1, 0, 4'h0, 14'd0, 1, 1, 0, 0};
    vecs[7]  = '{1, NS, 1, 3'd0, 32'h5, 32'h0000AB00, 1, 1, 4'h2, 14'd1, 0, 2, 0, 0};
    vecs[8]  = '{1, NS, 1, 3'd1, 32'h6, 32'hCDEF0000, 3, 1, 4'hC, 14'd1, 0, 4, 0, 0};
    vecs[9]  = '{0, NS, 1, 3'd2, 32'h4, 32'h0, 1, 1, 4'h0, 14'd1, 0, 2, 1, 32'hCDEFAB00};
    vecs[10] = '{1, NS, 1, 3'd3, 32'h0, 32'h0, 1, 0, 4'h0, 14'd0, 1, 1, 0, 0};
    vecs[11] = '{1, 2'b01, 1, 3'd2, 32'h0, 32'h0, 1, 0, 4'h0, 14'd0, 0, 0, 0, 0};
    vecs[12] = '{1, NS, 0, 3'd2, 32'h0, 32'h0, 1, 0, 4'h0, 14'd0, 0, 0, 0, 0};
    vecs[13] = '{0, NS, 1, 3'd2, 32'hFFFC, 32'h0, 1, 1, 4'h0, 14'h3FFF, 0, 2, 1, 32'h0BADF00D};
    vecs[14] = '{0, NS, 1, 3'd2, 32'h10, 32'h0, 4, 1, 4'h0, 14'd4, 0, 5, 1, 32'hDEADBEEF};
    vecs[15] = '{0, NS, 1, 3'd2, 32'h10, 32'h0, 0, 1, 4'h0, 14'd4, 1, 10, 0, 0};

    HRESET = 1; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 0; HBURST = 0;
    HWRITE = 0; HWDATA = 0; tb_hrdy = 1; sram_dout = 0;
    sram_write_done = 0; sram_read_valid = 0;
    step();
    step();
    chk("rst hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst hresp", 32'(HRESP), 32'd0);
    chk("rst hrdata", HRDATA, 32'h0);
    chk("rst strobes", {sram_we, sram_re, sram_maskwe}, 32'h0);
    chk("rst saddr", 32'(sram_addr), 32'h0);
    HRESET = 0;
    step();

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // late read completion after the timeout must be dropped
    sram_read_valid = 1; sram_dout = 32'hFFFFFFFF;
    step();
    sram_read_valid = 0;
    step();
    chk("late rv hrdata", HRDATA, 32'hDEADBEEF);
    chk("late rv hreadyout", 32'(HREADYOUT), 32'd1);
    chk("late rv hresp", 32'(HRESP), 32'd0);

    // reset while a write sits in WAIT
    HSEL = 1; HTRANS = NS; HADDR = 32'h20; HSIZE = 3'd2; HWRITE = 1;
    step();
    HSEL = 0; HTRANS = 0; HWDATA = 32'h55AA55AA;
    chk("mid write strobe", 32'(sram_we), 32'd1);
    step();
    step();
    HRESET = 1;
    step();
    HRESET = 0;
    chk("mid rst hreadyout", 32'(HREADYOUT), 32'd1);
    chk("mid rst hresp", 32'(HRESP), 32'd0);
    chk("mid rst strobes", {sram_we, sram_re, sram_maskwe}, 32'h0);
    chk("mid rst hrdata", HRDATA, 32'h0);
    chk("mid rst saddr", 32'(sram_addr), 32'h0);
    sram_write_done = 1;
    step();
    sram_write_done = 0;
    chk("post rst wd ignored", 32'(HREADYOUT), 32'd1);
    run_vec(16, '{0, NS, 1, 3'd2, 32'h10, 32'h0, 1, 1, 4'h0, 14'd4, 0, 2, 1, 32'hDEADBEEF});

    // INCR4 read burst, one-cycle completion, beats pipelined in DONE
    step();
    cyc = 0; beat = 0; nre = 0; guard = 0; pend = 0; fin = 0; pa = 0;
    HBURST = 3'b011;
    while (!fin && guard < 60) begin
      sram_read_valid = 0;
      if (pend) begin
        sram_read_valid = 1;
        sram_dout = mem[pa];
        q_brd.push_back(mem[pa]);
        pend = 0;
      end
      if (sram_re) begin
        nre++;
        pa = sram_addr;
        pend = 1;
        if (q_baddr.size() > 0)
          chk($sformatf("burst addr %0d", nre), 32'(sram_addr),
              32'(q_baddr.pop_front()));
      end
      if (HREADYOUT && beat > 0 && q_brd.size() > 0)
        chk($sformatf("burst rdata %0d", beat), HRDATA, q_brd.pop_front());
      if (HREADYOUT && beat < 4) begin
        HSEL = 1; HTRANS = (beat == 0) ? NS : SQ; HWRITE = 0;
        HSIZE = 3'd2; HADDR = 32'h100 + 32'(beat * 4);
        q_baddr.push_back(14'h40 + 14'(beat));
        beat++;
      end else if (HREADYOUT) begin
        HSEL = 0; HTRANS = 0;
        fin = 1;
      end
      if (!fin) begin
        step();
        cyc++;
        guard++;
      end
    end
    sram_read_valid = 0;
    if (!fin) begin
      n_total++;
      $display("FAIL burst timeout: %0d beats", beat);
    end
    chk("burst cycles", cyc, 12);
    chk("burst re count", nre, 4);
    step();
    chk("burst idle", 32'(HREADYOUT), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_spsram_bridge_v2.md
Name: ahb_spsram_bridge_v2

Overview:
Parametrised AHB-Lite slave that bridges single and burst (SEQ) transfers onto a single-port SRAM with variable-latency completion strobes. It succeeds the single-transfer bridge with these changes:
- HREADY qualification of the address phase.
- HSIZE-based byte-lane masks for writes.
- Address range and alignment checking with a two-cycle AHB ERROR response.
- A completion timeout.
- A registered read-data path.

It sits between the AHB interconnect and the SPRAM controller in the SoC memory subsystem.

Parameters:
- ADDR_W, 14: SRAM word-address width; word index = HADDR[ADDR_W+1:2].
- MEM_WORDS, 16384: number of populated words; word index >= MEM_WORDS is out of range.
- TIMEOUT, 255: maximum cycles spent in WAIT before an ERROR is returned; minimum 1.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HBURST  in  3  burst type; ignored, each beat is handled individually
- HWRITE  in  1  1 = write
- HREADY  in  1  bus ready
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  registered read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- sram_addr  out  ADDR_W  registered word address
- sram_we  out  1  one-cycle write strobe
- sram_re  out  1  one-cycle read strobe
- sram_maskwe  out  4  byte-lane enables; nonzero only while sram_we = 1
- sram_din  out  32  write data = HWDATA
- sram_dout  in  32  read data, valid with sram_read_valid
- sram_write_done  in  1  write completion pulse
- sram_read_valid  in  1  read completion pulse

Behaviour:
- Clock is HCLK; reset is synchronous and active-high (HRESET). This is already decided.
- Reset, including mid-transfer: state returns to IDLE and outputs take these values:
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - sram_we = sram_re = 0, sram_maskwe = 0, sram_addr = 0.
  - The timeout counter is cleared.
  - Completion pulses arriving after reset are ignored.
- accept = HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ). Transfers with HTRANS IDLE or BUSY are not accepted and receive a zero-wait OKAY response.
- Accepted transfers are sampled only in IDLE, DONE or ERR2, the states in which HREADYOUT = 1.
- On accept, the address-phase signals (HWRITE, word index, byte mask) are latched.
- Byte mask:
  - HSIZE = 0: 4'b0001 << HADDR[1:0]
  - HSIZE = 1: 4'b0011 << (2*HADDR[1])
  - HSIZE = 2: 4'b1111
- Error check at accept. Any of the following routes the transfer to ERR1 and issues no SRAM strobe:
  - HSIZE > 2.
  - HSIZE = 1 with HADDR[0] = 1.
  - HSIZE = 2 with HADDR[1:0] != 0.
  - Word index >= MEM_WORDS.
- FSM states:
  - IDLE: HREADYOUT = 1. On a valid accept go to ISSUE; on an erroneous accept go to ERR1.
  - ISSUE: one cycle with HREADYOUT = 0. Drives sram_re (read), or sram_we with sram_din = HWDATA and the latched mask (write). Goes to WAIT. Completion pulses seen in ISSUE are ignored.
  - WAIT: HREADYOUT = 0; the timeout counter increments each cycle.
    - Write: sram_write_done goes to DONE.
    - Read: sram_read_valid latches HRDATA <= sram_dout and goes to DONE.
    - The opposite-type pulse is ignored.
    - If the counter reaches TIMEOUT first, go to ERR1.
  - DONE: HREADYOUT = 1, HRESP = 0. HRDATA holds its value until the next read completes. Same accept logic as IDLE; with no accept, go to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1. Goes to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. Same accept logic as IDLE, so a pipelined next transfer is sampled here.
- Latency:
  - Strobe occurs 1 cycle after accept.
  - HREADYOUT rises 1 cycle after the completion pulse.
  - Minimum transfer is 3 cycles (accept, ISSUE, WAIT with immediate completion, then DONE).
  - Back-to-back SEQ beats incur no extra idle cycle.
- The timeout counter clears on leaving WAIT.
- sram_addr holds its last value between transfers.

Test Plan:
- Word write then read at HADDR = 0x0000_0010, data 0xDEADBEEF, SRAM completing 2 cycles after the strobe:
  - sram_addr = 4, sram_maskwe = 4'b1111.
  - HRDATA = 0xDEADBEEF.
  - HREADYOUT low for 3 cycles per beat; HRESP = 0.
- Byte write at HADDR = 0x0000_0003, then halfword write at HADDR = 0x0000_0002: sram_maskwe = 4'b1000, then 4'b1100.
- 4-beat INCR4 read burst at 0x0000_0100 with single-cycle completion:
  - sram_re pulses for addresses 0x40 through 0x43.
  - Next beat accepted in each DONE cycle.
  - Total of 12 cycles.
- Word access at HADDR = 0x0001_0000 (index 16384), and halfword access at HADDR = 0x1:
  - No SRAM strobe.
  - HRESP = 1 for 2 cycles; HREADYOUT = 0 then 1.
  - Next transfer proceeds normally.
- Read with no sram_read_valid and TIMEOUT = 8: ERR1 entered after 8 WAIT cycles; a sram_read_valid arriving later is ignored.
- HRESET asserted during WAIT of a write: next cycle HREADYOUT = 1, HRESP = 0, all strobes 0; a subsequent word read completes OKAY.
